// File: rtl/sb_uart_pkg.sv
// -----------------------------------------------------------------------------
// sb_uart_pkg
// Shared definitions for the string UART receive path: the bit-level FSM state
// encoding and the default framing constants that match the string transmitter.
// -----------------------------------------------------------------------------
package sb_uart_pkg;

  // Bit-level receiver states
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // End-of-message character ('#'); it is kept in the received string
  localparam logic [7:0] TERM_CHAR = 8'h23;

  // Width of the string bus in bytes
  localparam int MAX_STR_BYTES = 16;

endpackage

// File: rtl/sb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// sb_uart_rx_byte
// 8N1 byte receiver: 2-FF synchroniser, start/data/stop bit FSM and
// single-cycle byte-valid / framing-error strobes.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   data         last good byte, valid with byte_valid
//   byte_valid   one-cycle strobe: a byte with a good stop bit arrived
//   frame_err    one-cycle strobe: stop bit sampled low
//   idle         FSM is in IDLE (port exists only with SB_UART_RX_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module sb_uart_rx_byte
  import sb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
`ifdef SB_UART_RX_TIMEOUT_EN
  ,
  output logic       idle
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // The IDLE cycle that detects the falling edge counts as the first cycle of
  // the half bit, so START samples one count earlier than CLKS_PER_BIT/2-1.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_reg;
  logic          rxs;
  rx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    data_reg;
  logic          byte_valid_reg;
  logic          frame_err_reg;

  // Synchroniser resets to the idle (high) line level so reset never looks
  // like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!rxs) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
          end
        end
        S_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            // A line that is high again at mid start bit was a glitch
            state_reg <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_reg   <= bit_reg + 1'b1;
            if (bit_reg == 3'd7) begin
              state_reg <= S_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rxs) begin
              data_reg       <= shift_reg;
              byte_valid_reg <= 1'b1;
              state_reg      <= S_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= S_BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot be read as a stream of zero bytes.
          if (rxs) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign data       = data_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;
`ifdef SB_UART_RX_TIMEOUT_EN
  assign idle       = (state_reg == S_IDLE);
`endif

endmodule

// File: rtl/sb_1237_uart_rx.sv
// -----------------------------------------------------------------------------
// sb_1237_uart_rx
// UART string receiver: collects bytes from sb_uart_rx_byte into a
// right-justified 128-bit string and publishes it on the terminator
// character, on reaching MAX_LEN bytes, or (optionally) on line idle.
//
// Optional feature macro: SB_UART_RX_TIMEOUT_EN
//   defined   -> a partial message is published after IDLE_BITS idle bit times
//   undefined -> a partial message waits for TERM_CHAR or MAX_LEN
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx           serial input, idle high
//   str          message, first byte at [(str_len-1)*8 +: 8], last at [7:0]
//   str_len      byte count of str (1..MAX_LEN)
//   msg_valid    one-cycle pulse when str/str_len are updated
//   frame_err    one-cycle pulse on a bad stop bit
// -----------------------------------------------------------------------------
module sb_1237_uart_rx
  import sb_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int         MAX_LEN      = MAX_STR_BYTES,
  parameter logic [7:0] TERM_CHAR    = sb_uart_pkg::TERM_CHAR,
  parameter int         IDLE_BITS    = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx,
  output logic [MAX_STR_BYTES*8-1:0] str,
  output logic [7:0]                 str_len,
  output logic                       msg_valid,
  output logic                       frame_err
);

  localparam int SW = MAX_STR_BYTES * 8;

  if (MAX_LEN < 1 || MAX_LEN > MAX_STR_BYTES || IDLE_BITS < 1 || CLKS_PER_BIT < 4) begin : g_bad_params
    $error("sb_1237_uart_rx: parameter out of range");
  end

  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic          rx_frame_err;
  logic [SW-1:0] buf_reg;
  logic [SW-1:0] buf_shift;
  logic [4:0]    cnt_reg;
  logic [4:0]    cnt_inc;
  logic          is_last;
  logic          timeout_hit;
  logic [SW-1:0] str_reg;
  logic [7:0]    str_len_reg;
  logic          msg_valid_reg;
`ifdef SB_UART_RX_TIMEOUT_EN
  logic          rx_idle;
`endif

  sb_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (rx_byte),
    .byte_valid(rx_byte_valid),
    .frame_err (rx_frame_err)
`ifdef SB_UART_RX_TIMEOUT_EN
    ,
    .idle      (rx_idle)
`endif
  );

  // Buffer shifted left one byte with the new byte in lane 0
  assign buf_shift[7:0] = rx_byte;
  for (genvar gi = 1; gi < MAX_STR_BYTES; gi++) begin : g_lane
    assign buf_shift[gi*8 +: 8] = buf_reg[(gi-1)*8 +: 8];
  end

  assign cnt_inc = cnt_reg + 5'd1;
  assign is_last = (rx_byte == TERM_CHAR) || (cnt_inc == 5'(MAX_LEN));

`ifdef SB_UART_RX_TIMEOUT_EN
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int TW         = $clog2(IDLE_LIMIT);

  logic [TW-1:0] idle_cnt_reg;

  assign timeout_hit = rx_idle && (cnt_reg != 5'd0) && (idle_cnt_reg == TW'(IDLE_LIMIT - 1));

  // Runs only while a partial message waits; any start edge takes the byte
  // FSM out of IDLE and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (!rx_idle || cnt_reg == 5'd0 || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg       <= '0;
      cnt_reg       <= '0;
      str_reg       <= '0;
      str_len_reg   <= '0;
      msg_valid_reg <= 1'b0;
    end else begin
      msg_valid_reg <= 1'b0;
      if (rx_byte_valid) begin
        if (is_last) begin
          str_reg       <= buf_shift;
          str_len_reg   <= {3'b000, cnt_inc};
          msg_valid_reg <= 1'b1;
          buf_reg       <= '0;
          cnt_reg       <= '0;
        end else begin
          buf_reg <= buf_shift;
          cnt_reg <= cnt_inc;
        end
      end else if (rx_frame_err) begin
        // A corrupted byte poisons the whole message in progress
        buf_reg <= '0;
        cnt_reg <= '0;
      end else if (timeout_hit) begin
        str_reg       <= buf_reg;
        str_len_reg   <= {3'b000, cnt_reg};
        msg_valid_reg <= 1'b1;
        buf_reg       <= '0;
        cnt_reg       <= '0;
      end
    end
  end

  assign str       = str_reg;
  assign str_len   = str_len_reg;
  assign msg_valid = msg_valid_reg;
  assign frame_err = rx_frame_err;

endmodule

// File: tb/tb_sb_1237_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_sb_1237_uart_rx
// Directed bench for the UART string receiver. Uses a short bit period so the
// whole run stays small; all framing relations scale with CLKS_PER_BIT.
// -----------------------------------------------------------------------------
module tb_sb_1237_uart_rx;
  import sb_uart_pkg::*;

  localparam int CLKS      = 64;
  localparam int IDLE_BITS = 20;
  // sync (2) + half bit (CLKS/2) + 9 bit periods + publish (1)
  localparam int LATENCY   = 2 + CLKS / 2 + 9 * CLKS + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [127:0] str;
  logic [7:0]   str_len;
  logic         msg_valid;
  logic         frame_err;

  sb_1237_uart_rx #(
    .CLKS_PER_BIT(CLKS),
    .MAX_LEN     (16),
    .TERM_CHAR   (8'h23),
    .IDLE_BITS   (IDLE_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .str      (str),
    .str_len  (str_len),
    .msg_valid(msg_valid),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           mv_count = 0;
  int           fe_count = 0;
  int           mv_cyc = 0;
  int           last_start = 0;
  logic [127:0] cap_str = '0;
  logic [7:0]   cap_len = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-14s got %0h ok", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Capture every publish; msg_valid and frame_err must never coincide
  always @(negedge clk) begin
    if (rst_n) begin
      if (msg_valid) begin
        mv_count = mv_count + 1;
        cap_str  = str;
        cap_len  = str_len;
        mv_cyc   = cyc;
        check("excl_fe_mv", 128'(frame_err), 128'd0);
      end
      if (frame_err) fe_count = fe_count + 1;
    end
  end

  // Called at a negedge; leaves the line high after the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    last_start = cyc;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_msg(input logic [127:0] tx, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(tx[(n-1-i)*8 +: 8], 1'b1);
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] tx;
    int           n;
    logic [7:0]   exp_len;
    logic [127:0] exp_str;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int mv0;
    int fe0;
    logic [7:0] q;

    vecs[0] = '{"ab_term",  128'h414223, 3, 8'd3, 128'h414223};
    vecs[1] = '{"max_len",  128'h303132333435363738393A3B3C3D3E3F, 16, 8'd16,
                128'h303132333435363738393A3B3C3D3E3F};
    vecs[2] = '{"term_only", 128'h23, 1, 8'd1, 128'h23};
    vecs[3] = '{"max_term", 128'h30313233343536373839414243444523, 16, 8'd16,
                128'h30313233343536373839414243444523};
    vecs[4] = '{"hello",    128'h48656C6C6F23, 6, 8'd6, 128'h48656C6C6F23};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_str", str, 128'd0);
    check("rst_len", 128'(str_len), 128'd0);
    check("rst_mv", 128'(msg_valid), 128'd0);
    check("rst_fe", 128'(frame_err), 128'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven messages
    for (int v = 0; v < 5; v++) begin
      mv0 = mv_count;
      send_msg(vecs[v].tx, vecs[v].n);
      repeat (20) @(negedge clk);
      check({vecs[v].name, "_cnt"}, 128'(mv_count - mv0), 128'd1);
      check({vecs[v].name, "_len"}, 128'(cap_len), 128'(vecs[v].exp_len));
      check({vecs[v].name, "_str"}, cap_str, vecs[v].exp_str);
      check({vecs[v].name, "_lat"}, 128'(mv_cyc - last_start), 128'(LATENCY));
    end

    // Short low glitch shorter than half a bit
    mv0 = mv_count;
    fe0 = fe_count;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CLKS) @(negedge clk);
    check("glitch_mv", 128'(mv_count - mv0), 128'd0);
    check("glitch_fe", 128'(fe_count - fe0), 128'd0);
    check("glitch_idle", 128'(dut.u_byte.state_reg), 128'(S_IDLE));

    // Partial "A", then 0x55 with a low stop bit, then "Z#"
    mv0 = mv_count;
    fe0 = fe_count;
    send_byte(8'h41, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_fe", 128'(fe_count - fe0), 128'd1);
    check("ferr_mv", 128'(mv_count - mv0), 128'd0);
    send_msg(128'h5A23, 2);
    repeat (20) @(negedge clk);
    check("ferr_next_cnt", 128'(mv_count - mv0), 128'd1);
    check("ferr_next_len", 128'(cap_len), 128'd2);
    check("ferr_next_str", cap_str, 128'h5A23);

    // "X" committed, then reset during bit 4 of "Q"
    send_byte(8'h58, 1'b1);
    q = 8'h51;
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = q[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = q[4];
    repeat (CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_str", str, 128'd0);
    check("mid_rst_len", 128'(str_len), 128'd0);
    check("mid_rst_mv", 128'(msg_valid), 128'd0);
    check("mid_rst_fe", 128'(frame_err), 128'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    mv0 = mv_count;
    send_msg(128'h5123, 2);
    repeat (20) @(negedge clk);
    check("post_rst_cnt", 128'(mv_count - mv0), 128'd1);
    check("post_rst_len", 128'(cap_len), 128'd2);
    check("post_rst_str", cap_str, 128'h5123);

    // "HI" then line idle past the timeout window
    mv0 = mv_count;
    send_msg(128'h4849, 2);
    repeat ((IDLE_BITS + 2) * CLKS) @(negedge clk);
`ifdef SB_UART_RX_TIMEOUT_EN
    check("tmo_cnt", 128'(mv_count - mv0), 128'd1);
    check("tmo_len", 128'(cap_len), 128'd2);
    check("tmo_str", cap_str, 128'h4849);
    send_msg(128'h23, 1);
    repeat (20) @(negedge clk);
    check("tmo_next_len", 128'(cap_len), 128'd1);
    check("tmo_next_str", cap_str, 128'h23);
`else
    check("no_tmo_cnt", 128'(mv_count - mv0), 128'd0);
    send_msg(128'h23, 1);
    repeat (20) @(negedge clk);
    check("no_tmo_len", 128'(cap_len), 128'd3);
    check("no_tmo_str", cap_str, 128'h484923);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
